capture_seg: RTL and testbench
==============================

# capture_seg

Segmented, parametrised capture controller for the logic-analyzer core. It sits between the trigger module and the SDRAM write path. It delays incoming samples by a fixed plus programmable amount to align them with the trigger decision, and writes them into per-segment ring buffers. On each trigger it closes a segment of `sample_depth` samples and reports where that segment starts. Unlike the single-shot controller, it captures `seg_num` consecutive triggered segments per acquisition, with configurable data, address and delay widths.

## Interface
Parameters:
- `DW`, 16, sample data width.
- `AW`, 32, address and count width.
- `SEG_W`, 8, segment-count width.
- `FIX_DLY`, 3, fixed pipeline delay in cycles (≥1).
- `DLY_W`, 4, programmable-delay width; extra delay range is 0..2^DLY_W−1.

Ports:
- `core_clk`  in  1  sole clock.
- `core_rst`  in  1  reset, synchronous, active-high.
- `sample_en`  in  1  acquisition enable; a rising edge starts an acquisition, and a low level aborts one.
- `trig_en`  in  1  1 = triggered capture; 0 = immediate capture.
- `sample_depth`  in  AW  samples per segment (≥2).
- `trig_set_pos`  in  AW  number of pre-trigger samples per segment.
- `seg_num`  in  SEG_W  number of segments; 0 is treated as 1.
- `trig_dly`  in  DLY_W  extra data delay.
- `sample_valid`  in  1  input sample strobe.
- `sample_data`  in  DW  input sample.
- `trig_hit`  in  1  trigger condition, qualified by the delayed valid.
- `capture_valid`  out  1  write strobe.
- `capture_data`  out  DW  write data.
- `capture_addr`  out  AW  write address.
- `seg_done`  out  1  one-cycle pulse at the end of a segment.
- `seg_idx`  out  SEG_W  index of the current segment.
- `seg_start`  out  AW  address of the oldest sample in the just-closed segment; valid when `seg_done` is high.
- `capture_done`  out  1  one-cycle pulse at the end of the last segment.
- `busy`  out  1  high when the state is not IDLE.

## Operation
**Configuration latch.** On the `sample_en` rising edge, while in IDLE, latch all configuration inputs:
- `depth_l = sample_depth`.
- `pos_l = min(trig_set_pos, sample_depth−1)`, or 0 if `trig_en` = 0.
- `post_l = depth_l − pos_l`.
- `dly_l = trig_dly`.
- `nseg_l = max(seg_num, 1)`.
- Clear `seg_idx`, `wr_ptr`, `pre_cnt` and `seg_base`.
- Enter PRE. If `trig_en` = 0, enter POST instead.

Configuration changes after the latch have no effect until the next start.

**Delay line.** `dv`/`dd` are `sample_valid`/`sample_data` delayed by exactly `FIX_DLY + dly_l` cycles. The delay line runs in every state. Reset clears all stages to 0.

**Accepted sample.** A sample is accepted when `dv` = 1 and the state is PRE, ARMED or POST. On each accepted sample:
- Register `capture_valid` = 1, `capture_data` = `dd`, `capture_addr` = `seg_base + wr_ptr` (mod 2^AW).
- Advance `wr_ptr`, wrapping from `depth_l−1` to 0.

Cycles with `dv` = 0 change no counters.

**States:**
- **IDLE:** no samples are accepted. Exit only on a `sample_en` rising edge.
- **PRE:** `pre_cnt` counts accepted samples. Move to ARMED when `pre_cnt` reaches `pos_l`. If `pos_l` = 0, move to ARMED on the first cycle. `trig_hit` is ignored in PRE.
- **ARMED:** samples keep overwriting the ring. An accepted sample with `trig_hit` = 1 is the trigger sample: it counts as post sample 1, and the state moves to POST.
- **POST:** `post_cnt` counts accepted samples. When the sample making `post_cnt == post_l` is accepted:
  - Pulse `seg_done` and set `seg_start = seg_base + (final wr_ptr)`, which equals the trigger pointer minus `pos_l`, mod depth.
  - If this is the last segment (`seg_idx == nseg_l−1`), also pulse `capture_done` and go to IDLE.
  - Otherwise increment `seg_idx`, set `seg_base += depth_l`, and clear `wr_ptr`, `pre_cnt` and `post_cnt`. Go to PRE, or to POST if `trig_en` = 0. There is no dead cycle: the next accepted sample belongs to the new segment.

**Abort.** If `sample_en` is low in PRE, ARMED or POST, go to IDLE on the next edge. No `seg_done` or `capture_done` is issued, and `capture_valid` is 0 from that edge on.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, and the delay line is cleared. A reset mid-acquisition takes effect on the next edge with the same result.
- **Latency:** a `sample_valid` at edge t produces `capture_valid` at edge t + `FIX_DLY` + `dly_l` + 1. With the default parameters and `trig_dly` = 0 this is 4 cycles.
- **Pulse alignment:** `seg_done` and `capture_done` are asserted in the same cycle as the `capture_valid` of the final post sample. `seg_idx` updates on the following edge.
- **Trigger alignment:** `trig_hit` and `dv` are sampled on the same edge.
- **Back-pressure:** none.

## Test plan
1. **Single triggered segment.**
   - Stimulus: depth 8, pos 3, `trig_en` = 1, `seg_num` = 1, continuous valid data 0,1,2,…; `trig_hit` is high with the 6th delayed sample (data 5).
   - Required: write addresses are 0,1,2,3,4,5,6,7,0,1; `seg_done` and `capture_done` are high with the write of data 9; `seg_start` = 2.
2. **Trigger ignored in PRE.**
   - Stimulus: as in test 1, but `trig_hit` is high only on sample 1.
   - Required: no transition to POST; `busy` stays high.
3. **Three segments.**
   - Stimulus: depth 4, pos 1, `seg_num` = 3; trigger on the 2nd sample of each segment.
   - Required: `seg_base` values 0, 4 and 8; three `seg_done` pulses, each with `seg_start` = base + 0; `capture_done` only on the third.
4. **Immediate mode.**
   - Stimulus: `trig_en` = 0, depth 4, `seg_num` = 2.
   - Required: addresses 0..7; `seg_start` = 0, then 4; `capture_done` with address 7.
5. **Delay and gaps.**
   - Stimulus: `trig_dly` = 5, a single valid pulse followed by alternating valid gaps.
   - Required: first `capture_valid` exactly 9 cycles after the pulse; the address advances only on valid cycles.
6. **Abort and reset.**
   - Stimulus: drop `sample_en` in ARMED, then restart; later assert `core_rst` in POST.
   - Required: `capture_valid` is 0 from the next edge; no done pulses; after the restart addresses begin at 0; after the reset all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/capture_seg_if.sv
// Sample stream into the capture controller and write stream out to the SDRAM path.
interface capture_seg_if #(
  parameter int DW = 16,
  parameter int AW = 32
);
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          trig_hit;
  logic          capture_valid;
  logic [DW-1:0] capture_data;
  logic [AW-1:0] capture_addr;

  modport master (
    output sample_valid, sample_data, trig_hit,
    input  capture_valid, capture_data, capture_addr
  );

  modport slave (
    input  sample_valid, sample_data, trig_hit,
    output capture_valid, capture_data, capture_addr
  );
endinterface

// File: rtl/capture_seg.sv
// Segmented capture controller: delays samples to line up with the trigger decision
// and writes seg_num triggered segments into consecutive ring buffers.
module capture_seg #(
  parameter int DW      = 16,
  parameter int AW      = 32,
  parameter int SEG_W   = 8,
  parameter int FIX_DLY = 3,
  parameter int DLY_W   = 4
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             sample_en,
  input  logic             trig_en,
  input  logic [AW-1:0]    sample_depth,
  input  logic [AW-1:0]    trig_set_pos,
  input  logic [SEG_W-1:0] seg_num,
  input  logic [DLY_W-1:0] trig_dly,
  capture_seg_if.slave     bus,
  output logic             seg_done,
  output logic [SEG_W-1:0] seg_idx,
  output logic [AW-1:0]    seg_start,
  output logic             capture_done,
  output logic             busy
);

  localparam int DL = FIX_DLY + (1 << DLY_W);
  localparam int TW = $clog2(DL);

  typedef enum logic [1:0] {IDLE, PRE, ARMED, POST} state_t;

  state_t           state;
  logic             en_q;
  logic             trig_en_l;
  logic [AW-1:0]    depth_l;
  logic [AW-1:0]    pos_l;
  logic [AW-1:0]    post_l;
  logic [DLY_W-1:0] dly_l;
  logic [SEG_W-1:0] nseg_l;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    pre_cnt;
  logic [AW-1:0]    post_cnt;
  logic [AW-1:0]    seg_base;
  logic             seg_inc;

  logic [DL-1:0]    dv_pipe;
  logic [DW-1:0]    dd_pipe [DL];

  logic [TW-1:0]    tap;
  logic             dv;
  logic [DW-1:0]    dd;
  logic             accept;
  logic [AW-1:0]    wr_next;
  logic [AW-1:0]    post_next;
  logic             close;
  logic             last_seg;
  logic             start;
  logic [AW-1:0]    pos_in;

  // Stage k holds the input sampled k+1 edges ago, so tapping FIX_DLY+dly_l gives
  // a total latency of FIX_DLY+dly_l+1 once the output register is included.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      dv_pipe <= '0;
      for (int i = 0; i < DL; i++) dd_pipe[i] <= '0;
    end else begin
      dv_pipe    <= {dv_pipe[DL-2:0], bus.sample_valid};
      dd_pipe[0] <= bus.sample_data;
      for (int i = 1; i < DL; i++) dd_pipe[i] <= dd_pipe[i-1];
    end
  end

  always_comb begin
    tap       = TW'(FIX_DLY) + TW'(dly_l);
    dv        = dv_pipe[tap];
    dd        = dd_pipe[tap];
    accept    = dv && (state != IDLE);
    wr_next   = (wr_ptr == depth_l - AW'(1)) ? '0 : wr_ptr + AW'(1);
    post_next = (state == ARMED) ? AW'(1) : post_cnt + AW'(1);
    close     = accept && ((state == POST) || (state == ARMED && bus.trig_hit))
                && (post_next == post_l);
    last_seg  = (seg_idx == nseg_l - SEG_W'(1));
    start     = sample_en && !en_q && (state == IDLE);
    pos_in    = '0;
    if (trig_en)
      pos_in = (trig_set_pos > sample_depth - AW'(1)) ? sample_depth - AW'(1) : trig_set_pos;
  end

  assign busy = (state != IDLE);

  // seg_idx lags the closing edge by one cycle, so seg_done is reported with the
  // index of the segment it closes.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state             <= IDLE;
      en_q              <= 1'b0;
      trig_en_l         <= 1'b0;
      depth_l           <= '0;
      pos_l             <= '0;
      post_l            <= '0;
      dly_l             <= '0;
      nseg_l            <= '0;
      wr_ptr            <= '0;
      pre_cnt           <= '0;
      post_cnt          <= '0;
      seg_base          <= '0;
      seg_inc           <= 1'b0;
      seg_idx           <= '0;
      seg_start         <= '0;
      seg_done          <= 1'b0;
      capture_done      <= 1'b0;
      bus.capture_valid <= 1'b0;
      bus.capture_data  <= '0;
      bus.capture_addr  <= '0;
    end else begin
      en_q              <= sample_en;
      bus.capture_valid <= 1'b0;
      seg_done          <= 1'b0;
      capture_done      <= 1'b0;
      seg_inc           <= 1'b0;
      if (seg_inc) seg_idx <= seg_idx + SEG_W'(1);

      if (state == IDLE) begin
        if (start) begin
          trig_en_l <= trig_en;
          depth_l   <= sample_depth;
          pos_l     <= pos_in;
          post_l    <= sample_depth - pos_in;
          dly_l     <= trig_dly;
          nseg_l    <= (seg_num == '0) ? SEG_W'(1) : seg_num;
          seg_idx   <= '0;
          wr_ptr    <= '0;
          pre_cnt   <= '0;
          post_cnt  <= '0;
          seg_base  <= '0;
          state     <= trig_en ? PRE : POST;
        end
      end else if (!sample_en) begin
        state <= IDLE;
      end else begin
        if (accept) begin
          bus.capture_valid <= 1'b1;
          bus.capture_data  <= dd;
          bus.capture_addr  <= seg_base + wr_ptr;
          wr_ptr            <= wr_next;
        end

        case (state)
          PRE: begin
            if (pos_l == '0) begin
              state <= ARMED;
            end else if (accept) begin
              pre_cnt <= pre_cnt + AW'(1);
              if (pre_cnt + AW'(1) == pos_l) state <= ARMED;
            end
          end
          ARMED: begin
            if (accept && bus.trig_hit) begin
              post_cnt <= AW'(1);
              state    <= POST;
            end
          end
          POST: begin
            if (accept) post_cnt <= post_next;
          end
          default: ;
        endcase

        // Closing a segment hands straight over to the next one with no dead cycle.
        if (close) begin
          seg_done  <= 1'b1;
          seg_start <= seg_base + wr_next;
          if (last_seg) begin
            capture_done <= 1'b1;
            state        <= IDLE;
          end else begin
            seg_inc  <= 1'b1;
            seg_base <= seg_base + depth_l;
            wr_ptr   <= '0;
            pre_cnt  <= '0;
            post_cnt <= '0;
            state    <= trig_en_l ? PRE : POST;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_capture_seg.sv
// Directed bench for capture_seg: triggered, multi-segment, immediate, delayed,
// abort and reset scenarios with hand-computed expectations.
module tb_capture_seg;

  logic        core_clk;
  logic        core_rst;
  logic        sample_en;
  logic        trig_en;
  logic [31:0] sample_depth;
  logic [31:0] trig_set_pos;
  logic [7:0]  seg_num;
  logic [3:0]  trig_dly;
  logic        seg_done;
  logic [7:0]  seg_idx;
  logic [31:0] seg_start;
  logic        capture_done;
  logic        busy;

  int checks;
  int errors;
  int i;

  capture_seg_if #(.DW(16), .AW(32)) bus ();

  capture_seg dut (
    .core_clk     (core_clk),
    .core_rst     (core_rst),
    .sample_en    (sample_en),
    .trig_en      (trig_en),
    .sample_depth (sample_depth),
    .trig_set_pos (trig_set_pos),
    .seg_num      (seg_num),
    .trig_dly     (trig_dly),
    .bus          (bus),
    .seg_done     (seg_done),
    .seg_idx      (seg_idx),
    .seg_start    (seg_start),
    .capture_done (capture_done),
    .busy         (busy)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic en, input logic v, input logic [15:0] d,
                               input logic h);
    sample_en        = en;
    bus.sample_valid = v;
    bus.sample_data  = d;
    bus.trig_hit     = h;
    @(posedge core_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    core_rst         = 1'b1;
    sample_en        = 1'b0;
    trig_en          = 1'b1;
    sample_depth     = 32'd8;
    trig_set_pos     = 32'd3;
    seg_num          = 8'd1;
    trig_dly         = 4'd0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.trig_hit     = 1'b0;

    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_valid", bus.capture_valid, 0);
    checkOutput("rst_data", bus.capture_data, 0);
    checkOutput("rst_addr", bus.capture_addr, 0);
    checkOutput("rst_seg_done", seg_done, 0);
    checkOutput("rst_seg_idx", seg_idx, 0);
    checkOutput("rst_seg_start", seg_start, 0);
    checkOutput("rst_cap_done", capture_done, 0);
    checkOutput("rst_busy", busy, 0);
    core_rst = 1'b0;
    applyStimulus(0, 0, 0, 0);

    // Single triggered segment, trigger on sample 5.
    $display("[TB] single triggered segment");
    applyStimulus(1, 0, 0, 0);
    checkOutput("t1_busy_start", busy, 1);
    for (int j = 1; j <= 16; j++) begin
      applyStimulus(1, 1, 16'(j - 1), j == 10);
      i = j - 5;
      if (i >= 0 && i <= 9) begin
        checkOutput("t1_valid", bus.capture_valid, 1);
        checkOutput("t1_data", bus.capture_data, i);
        checkOutput("t1_addr", bus.capture_addr, i % 8);
        checkOutput("t1_seg_done", seg_done, i == 9);
        checkOutput("t1_cap_done", capture_done, i == 9);
        if (i == 9) begin
          checkOutput("t1_seg_start", seg_start, 2);
          checkOutput("t1_seg_idx", seg_idx, 0);
        end
      end else if (i == 10) begin
        checkOutput("t1_valid_after", bus.capture_valid, 0);
        checkOutput("t1_busy_after", busy, 0);
      end
    end
    for (int j = 0; j < 24; j++) applyStimulus(0, 0, 0, 0);

    // Trigger only while in PRE must be ignored; then abort in ARMED and restart.
    $display("[TB] trigger ignored in PRE, abort, restart, reset");
    applyStimulus(1, 0, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(1, 1, 16'(j - 1), j == 6);
      i = j - 5;
      if (i >= 0) begin
        checkOutput("t2_addr", bus.capture_addr, i % 8);
        checkOutput("t2_seg_done", seg_done, 0);
      end
    end
    checkOutput("t2_busy", busy, 1);
    applyStimulus(0, 1, 16'd20, 0);
    checkOutput("t6_abort_valid", bus.capture_valid, 0);
    checkOutput("t6_abort_busy", busy, 0);
    checkOutput("t6_abort_seg_done", seg_done, 0);
    checkOutput("t6_abort_cap_done", capture_done, 0);
    applyStimulus(0, 1, 16'd21, 0);
    checkOutput("t6_idle_valid", bus.capture_valid, 0);
    applyStimulus(1, 1, 16'd22, 0);
    checkOutput("t6_start_valid", bus.capture_valid, 0);
    applyStimulus(1, 1, 16'd23, 0);
    checkOutput("t6_restart_valid", bus.capture_valid, 1);
    checkOutput("t6_restart_addr0", bus.capture_addr, 0);
    applyStimulus(1, 1, 16'd24, 0);
    checkOutput("t6_restart_addr1", bus.capture_addr, 1);
    applyStimulus(1, 1, 16'd25, 0);
    applyStimulus(1, 1, 16'd26, 1);
    checkOutput("t6_trig_addr", bus.capture_addr, 3);
    applyStimulus(1, 1, 16'd27, 0);
    checkOutput("t6_post_addr", bus.capture_addr, 4);
    checkOutput("t6_post_busy", busy, 1);
    core_rst = 1'b1;
    applyStimulus(0, 1, 16'd28, 0);
    checkOutput("t6_rst_valid", bus.capture_valid, 0);
    checkOutput("t6_rst_data", bus.capture_data, 0);
    checkOutput("t6_rst_addr", bus.capture_addr, 0);
    checkOutput("t6_rst_seg_done", seg_done, 0);
    checkOutput("t6_rst_seg_idx", seg_idx, 0);
    checkOutput("t6_rst_seg_start", seg_start, 0);
    checkOutput("t6_rst_cap_done", capture_done, 0);
    checkOutput("t6_rst_busy", busy, 0);
    core_rst = 1'b0;
    for (int j = 0; j < 24; j++) applyStimulus(0, 0, 0, 0);

    // Three segments of depth 4, one pre sample, trigger on each 2nd sample.
    $display("[TB] three segments");
    sample_depth = 32'd4;
    trig_set_pos = 32'd1;
    seg_num      = 8'd3;
    applyStimulus(1, 0, 0, 0);
    for (int j = 1; j <= 18; j++) begin
      applyStimulus(1, 1, 16'(j - 1), (j == 6) || (j == 10) || (j == 14));
      i = j - 5;
      if (i >= 0 && i <= 11) begin
        checkOutput("t3_addr", bus.capture_addr, i);
        checkOutput("t3_seg_done", seg_done, (i % 4) == 3);
        checkOutput("t3_cap_done", capture_done, i == 11);
        if ((i % 4) == 3) begin
          checkOutput("t3_seg_start", seg_start, i - 3);
          checkOutput("t3_seg_idx", seg_idx, i / 4);
        end
        if (i == 4) checkOutput("t3_seg_idx_next", seg_idx, 1);
      end else if (i == 12) begin
        checkOutput("t3_valid_after", bus.capture_valid, 0);
        checkOutput("t3_busy_after", busy, 0);
      end
    end
    for (int j = 0; j < 24; j++) applyStimulus(0, 0, 0, 0);

    // Immediate capture, two segments of depth 4; trig_set_pos is ignored.
    $display("[TB] immediate mode");
    trig_en      = 1'b0;
    trig_set_pos = 32'd2;
    seg_num      = 8'd2;
    applyStimulus(1, 0, 0, 0);
    for (int j = 1; j <= 14; j++) begin
      applyStimulus(1, 1, 16'(j - 1), 0);
      i = j - 5;
      if (i >= 0 && i <= 7) begin
        checkOutput("t4_addr", bus.capture_addr, i);
        checkOutput("t4_seg_done", seg_done, (i == 3) || (i == 7));
        checkOutput("t4_cap_done", capture_done, i == 7);
        if (i == 3) checkOutput("t4_seg_start0", seg_start, 0);
        if (i == 7) checkOutput("t4_seg_start1", seg_start, 4);
      end else if (i == 8) begin
        checkOutput("t4_busy_after", busy, 0);
      end
    end
    for (int j = 0; j < 24; j++) applyStimulus(0, 0, 0, 0);

    // Extra delay of 5: one pulse then alternating gaps, latency 9 cycles.
    $display("[TB] delay and gaps");
    sample_depth = 32'd8;
    seg_num      = 8'd1;
    trig_dly     = 4'd5;
    applyStimulus(1, 0, 0, 0);
    for (int j = 1; j <= 26; j++) begin
      applyStimulus(1, (j == 1) || (j >= 11 && j <= 15 && (j % 2) == 1), 16'(160 + j), 0);
      if (j >= 2) checkOutput("t5_valid", bus.capture_valid,
                              (j == 10) || (j == 20) || (j == 22) || (j == 24));
      if (j == 10) begin
        checkOutput("t5_addr0", bus.capture_addr, 0);
        checkOutput("t5_data0", bus.capture_data, 16'hA1);
      end
      if (j == 20) begin
        checkOutput("t5_addr1", bus.capture_addr, 1);
        checkOutput("t5_data1", bus.capture_data, 16'hAB);
      end
      if (j == 22) checkOutput("t5_addr2", bus.capture_addr, 2);
      if (j == 24) begin
        checkOutput("t5_addr3", bus.capture_addr, 3);
        checkOutput("t5_data3", bus.capture_data, 16'hAF);
      end
    end
    checkOutput("t5_busy", busy, 1);
    for (int j = 0; j < 4; j++) applyStimulus(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
